issue_queue_mp: RTL and testbench

- Parametrised multi-port in-order issue queue between the decode stage and dispatch.
- Accepts up to ENQ_WIDTH decoded ops per cycle, with any subset of lanes valid. Valid lanes are compacted into consecutive slots.
- Presents the oldest DEQ_WIDTH entries to dispatch, which pops an in-order prefix.
- Supports pipeline flush, backpressure and per-lane valid reporting. Replaces the fixed two-wide queue behind the decoder.

---
 rtl/issue_queue_mp.sv | 173 +++++++++++++++++
 tb/tb_issue_queue_mp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_mp.sv
// issue_queue_mp: multi-port in-order issue queue between decode and dispatch.
// Valid enqueue lanes are compacted into consecutive slots of a circular
// buffer. The oldest DEQ_WIDTH entries are shown to dispatch, which pops an
// in-order prefix.
// Optional build macro: ISSUE_QUEUE_BYPASS_EN. When it is defined, an empty
// queue forwards the compacted enqueue lanes to the dequeue outputs in the
// same cycle.
module issue_queue_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ENQ_WIDTH  = 2,
  parameter int DEQ_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [ENQ_WIDTH-1:0]            enq_valid,
  input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data,
  output logic                            enq_ready,
  output logic [DEQ_WIDTH-1:0]            deq_valid,
  output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data,
  input  logic [DEQ_WIDTH-1:0]            deq_en,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            full,
  output logic                            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] enq_lane [ENQ_WIDTH];
  logic [CNT_W-1:0]      enq_off  [ENQ_WIDTH];
  logic [CNT_W-1:0]      enq_n;
  logic [CNT_W-1:0]      enq_acc;
  logic [CNT_W-1:0]      pop_n;
  logic [CNT_W-1:0]      skip_n;
  logic                  pop_run;
  logic [ENQ_WIDTH-1:0]  wr_en;
  logic [PTR_W-1:0]      wr_addr [ENQ_WIDTH];
  logic [DEQ_WIDTH-1:0]  deq_valid_int;
  logic [DATA_WIDTH-1:0] deq_data_int [DEQ_WIDTH];

  // Lane unpack / pack between the flat buses and per-lane arrays.
  genvar gi;
  generate
    for (gi = 0; gi < ENQ_WIDTH; gi++) begin : g_enq_lane
      assign enq_lane[gi] = enq_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq_lane
      assign deq_data[gi*DATA_WIDTH +: DATA_WIDTH] = deq_data_int[gi];
    end
  endgenerate

  // Space check uses only the registered count, so deq_en never reaches enq_ready.
  assign enq_ready = (count_q <= CNT_W'(DEPTH - ENQ_WIDTH));
  assign full      = ~enq_ready;
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign deq_valid = deq_valid_int;

  // Compaction: each valid lane's slot offset is the number of valid lanes below it.
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      enq_off[i] = enq_n;
      if (enq_valid[i]) begin
        enq_n = enq_n + CNT_W'(1);
      end
    end
  end

`ifdef ISSUE_QUEUE_BYPASS_EN
  logic                  bypass_act;
  logic [DEQ_WIDTH-1:0]  byp_valid;
  logic [DATA_WIDTH-1:0] byp_data [DEQ_WIDTH];

  assign bypass_act = (count_q == '0) && enq_ready;

  // Bypass sources: dequeue lane k takes the k-th valid enqueue lane.
  always_comb begin
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      byp_valid[k] = 1'b0;
      byp_data[k]  = '0;
    end
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      for (int k = 0; k < DEQ_WIDTH; k++) begin
        if (enq_valid[i] && (enq_off[i] == CNT_W'(k))) begin
          byp_valid[k] = 1'b1;
          byp_data[k]  = enq_lane[i];
        end
      end
    end
  end
`endif

  // Dispatch view: oldest entries from head, zeroed on lanes that hold nothing.
  always_comb begin
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      deq_valid_int[k] = (count_q > CNT_W'(k));
      deq_data_int[k]  = deq_valid_int[k] ? mem_q[head_q + PTR_W'(k)] : '0;
`ifdef ISSUE_QUEUE_BYPASS_EN
      if (bypass_act) begin
        deq_valid_int[k] = byp_valid[k];
        deq_data_int[k]  = byp_data[k];
      end
`endif
    end
  end

  // Next state: prefix pop count, write slots and pointer/count updates.
  always_comb begin
    pop_n   = '0;
    pop_run = 1'b1;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      pop_run = pop_run & deq_en[k] & deq_valid_int[k];
      if (pop_run) begin
        pop_n = pop_n + CNT_W'(1);
      end
    end

    enq_acc = enq_ready ? enq_n : '0;

    // Entries consumed straight off the enqueue lanes never touch storage.
`ifdef ISSUE_QUEUE_BYPASS_EN
    skip_n = bypass_act ? pop_n : '0;
`else
    skip_n = '0;
`endif

    for (int i = 0; i < ENQ_WIDTH; i++) begin
      wr_en[i]   = enq_ready && enq_valid[i] && !rst && !flush && (enq_off[i] >= skip_n);
      wr_addr[i] = tail_q + PTR_W'(enq_off[i] - skip_n);
    end

    head_d  = head_q + PTR_W'(pop_n - skip_n);
    tail_d  = tail_q + PTR_W'(enq_acc - skip_n);
    count_d = count_q + enq_acc - pop_n;
  end

  // Pointer and count registers; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_addr[i]] <= enq_lane[i];
      end
    end
  end

  // Occupancy stays within 0..DEPTH.
  a_count_max: assert property (@(posedge clk) disable iff (rst)
    count_q <= CNT_W'(DEPTH));
  a_count_min: assert property (@(posedge clk) disable iff (rst || flush)
    ({1'b0, count_q} + {1'b0, enq_acc}) >= {1'b0, pop_n});

endmodule

// File: tb/tb_issue_queue_mp.sv
// Testbench for issue_queue_mp (DEPTH=8, two enqueue and two dequeue lanes).
// Table rows carry stimulus plus expected count/ready/full/empty; dequeue
// lanes are checked against a scoreboard queue of expected entries.
module tb_issue_queue_mp;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int EW    = 2;
  localparam int DQ    = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [EW-1:0]     enq_valid;
  logic [EW*DW-1:0]  enq_data;
  logic              enq_ready;
  logic [DQ-1:0]     deq_valid;
  logic [DQ*DW-1:0]  deq_data;
  logic [DQ-1:0]     deq_en;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  int nvec = 0;
  int nerr = 0;
  logic [DW-1:0] sb [$];

  typedef struct {
    logic        r;
    logic        f;
    logic [1:0]  ev;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  de;
    int          cnt;
    logic        rdy;
    logic        fl;
    logic        emp;
  } vec_t;

  vec_t tbl [26];

  issue_queue_mp #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ENQ_WIDTH(EW), .DEQ_WIDTH(DQ)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_en(deq_en),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic f, input logic [1:0] ev,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] de, input int cnt,
                              input logic rdy, input logic fl, input logic emp);
    vec_t v;
    v.r = r; v.f = f; v.ev = ev; v.d0 = d0; v.d1 = d1; v.de = de;
    v.cnt = cnt; v.rdy = rdy; v.fl = fl; v.emp = emp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row: drive, check pre-edge outputs against table and scoreboard, clock, update model.
  task automatic apply(input vec_t v, input int idx);
    logic [DW-1:0] lanes [$];
    logic [DW-1:0] vis [$];
    logic [DQ-1:0] exp_dv;
    logic [DW-1:0] exp_d;
    logic          ready_m;
    bit            byp;
    int            pop;
    rst = v.r; flush = v.f; enq_valid = v.ev; enq_data = {v.d1, v.d0}; deq_en = v.de;
    #1;
    ready_m = (sb.size() <= DEPTH - EW);
    if (v.ev[0]) lanes.push_back(v.d0);
    if (v.ev[1]) lanes.push_back(v.d1);
    byp = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
    if (sb.size() == 0 && ready_m) byp = 1'b1;
`endif
    if (byp) begin
      foreach (lanes[j]) vis.push_back(lanes[j]);
    end else begin
      foreach (sb[j]) vis.push_back(sb[j]);
    end

    chk($sformatf("v%0d count", idx), 64'(count), 64'(v.cnt));
    chk($sformatf("v%0d enq_ready", idx), 64'(enq_ready), 64'(v.rdy));
    chk($sformatf("v%0d full", idx), 64'(full), 64'(v.fl));
    chk($sformatf("v%0d empty", idx), 64'(empty), 64'(v.emp));
    for (int k = 0; k < DQ; k++) begin
      exp_dv[k] = (k < vis.size());
      exp_d     = (k < vis.size()) ? vis[k] : '0;
      chk($sformatf("v%0d deq_data[%0d]", idx, k), 64'(deq_data[k*DW +: DW]), 64'(exp_d));
    end
    chk($sformatf("v%0d deq_valid", idx), 64'(deq_valid), 64'(exp_dv));

    pop = 0;
    for (int k = 0; k < DQ; k++) begin
      if (deq_en[k] && exp_dv[k] && pop == k) pop++;
    end
    if (v.r || v.f) begin
      sb.delete();
    end else if (byp) begin
      for (int j = pop; j < lanes.size(); j++) sb.push_back(lanes[j]);
    end else begin
      for (int j = 0; j < pop; j++) void'(sb.pop_front());
      if (ready_m) foreach (lanes[j]) sb.push_back(lanes[j]);
    end
    $display("vec %0d: rst=%0b flush=%0b ev=%b de=%b count=%0d popped=%0d model_size=%0d",
             idx, v.r, v.f, v.ev, v.de, count, pop, sb.size());
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //             r  f  ev     d0     d1     de     cnt rdy fl emp
    tbl[0]  = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b00, 0, 1, 0, 1);
    tbl[1]  = mk(0, 0, 2'b10, 32'h0,  32'hA1, 2'b00, 0, 1, 0, 1);
    tbl[2]  = mk(0, 0, 2'b11, 32'hB0, 32'hB1, 2'b00, 1, 1, 0, 0);
    tbl[3]  = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b00, 3, 1, 0, 0);
    tbl[4]  = mk(0, 1, 2'b00, 32'h0,  32'h0,  2'b00, 3, 1, 0, 0);
    tbl[5]  = mk(0, 0, 2'b11, 32'h10, 32'h11, 2'b00, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0, 2'b11, 32'h12, 32'h13, 2'b00, 2, 1, 0, 0);
    tbl[7]  = mk(0, 0, 2'b11, 32'h14, 32'h15, 2'b00, 4, 1, 0, 0);
    tbl[8]  = mk(0, 0, 2'b11, 32'h16, 32'h17, 2'b00, 6, 1, 0, 0);
    tbl[9]  = mk(0, 0, 2'b11, 32'h18, 32'h19, 2'b00, 8, 0, 1, 0);
    tbl[10] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b00, 8, 0, 1, 0);
    tbl[11] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 8, 0, 1, 0);
    tbl[12] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 6, 1, 0, 0);
    tbl[13] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 4, 1, 0, 0);
    tbl[14] = mk(0, 0, 2'b01, 32'h20, 32'h0,  2'b01, 2, 1, 0, 0);
    tbl[15] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b10, 2, 1, 0, 0);
    tbl[16] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b11, 2, 1, 0, 0);
    tbl[17] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b00, 0, 1, 0, 1);
    tbl[18] = mk(0, 0, 2'b11, 32'h30, 32'h31, 2'b00, 0, 1, 0, 1);
    tbl[19] = mk(0, 0, 2'b11, 32'h32, 32'h33, 2'b00, 2, 1, 0, 0);
    tbl[20] = mk(0, 0, 2'b01, 32'h34, 32'h0,  2'b00, 4, 1, 0, 0);
    tbl[21] = mk(0, 1, 2'b11, 32'h35, 32'h36, 2'b11, 5, 1, 0, 0);
    tbl[22] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b00, 0, 1, 0, 1);
    tbl[23] = mk(0, 0, 2'b11, 32'h40, 32'h41, 2'b00, 0, 1, 0, 1);
    tbl[24] = mk(1, 0, 2'b11, 32'h42, 32'h43, 2'b11, 2, 1, 0, 0);
    tbl[25] = mk(0, 0, 2'b00, 32'h0,  32'h0,  2'b00, 0, 1, 0, 1);

    rst = 1'b1; flush = 1'b0; enq_valid = '0; enq_data = '0; deq_en = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i], i);
    end

    // Wrapped pop order: slots 7 then 0 were popped in row 16, verified via scoreboard.
    // Same-cycle forwarding on an empty queue.
`ifdef ISSUE_QUEUE_BYPASS_EN
    rst = 1'b0; flush = 1'b0;
    enq_valid = 2'b11; enq_data = {32'hC1, 32'hC0}; deq_en = 2'b01;
    #1;
    chk("byp lane0 same cycle", 64'(deq_data[DW-1:0]), 64'h0000_00C0);
    $display("byp: enq C0/C1 deq_en=01 lane0=%0h", deq_data[DW-1:0]);
    @(posedge clk);
    @(negedge clk);
    enq_valid = '0; deq_en = '0;
    #1;
    chk("byp count next", 64'(count), 64'd1);
    chk("byp lane0 next", 64'(deq_data[DW-1:0]), 64'h0000_00C1);
    $display("byp: next cycle count=%0d lane0=%0h", count, deq_data[DW-1:0]);
    @(posedge clk);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
